hazard_stall_unit: RTL and testbench

- Stall and bubble generator for the 5-stage MIPS pipeline; the consumer-side counterpart of the forwarding logic.
- Detects hazards that forwarding cannot cover:
  - load-use into EX;
  - load result needed by an ID-stage branch or jr;
  - dependence on the in-flight multi-cycle mult/div unit (MDU).
- Sits between ID and ID_EX.
- Drives PC/IF_ID hold and ID_EX bubble insertion.
- Owns the MDU busy timer and a stall-cycle performance counter.

---
 rtl/hazard_stall_unit_pkg.sv | 28 ++
 rtl/hazard_stall_unit_mdu_busy_timer.sv | 73 +++++++
 rtl/hazard_stall_unit.sv | 97 +++++++++
 tb/tb_hazard_stall_unit.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_stall_unit_pkg.sv
// Shared types and constants for the pipeline hazard/stall logic.
// Register numbers are 5-bit MIPS GPR indices; $0 is hardwired zero.
package my_lib;

    typedef enum logic [1:0] {
        NONE        = 2'd0,
        LOAD_USE    = 2'd1,
        BRANCH_LOAD = 2'd2,
        MDU         = 2'd3
    } stall_cause_t;

    localparam int MULT_LAT_DEF = 5;
    localparam int DIV_LAT_DEF  = 32;

    localparam logic [4:0] REG_ZERO = 5'd0;

    // True when a producer's destination feeds a source the ID instruction actually reads.
    function automatic logic src_match(
        input logic [4:0] dst,
        input logic [4:0] rs,
        input logic [4:0] rt,
        input logic       use_rs,
        input logic       use_rt
    );
        return (dst != REG_ZERO) && ((use_rs && (dst == rs)) || (use_rt && (dst == rt)));
    endfunction

endpackage

// File: rtl/hazard_stall_unit_mdu_busy_timer.sv
// Occupancy timer for the multi-cycle mult/div unit: tracks BUSY, and pulses
// done for one cycle after the last busy cycle so HI/LO can be consumed.
module mdu_busy_timer
    import my_lib::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic start,
    input  logic is_div,
    output logic busy,
    output logic done,
    output logic done_next
);

    localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
    localparam int CTR_W   = $clog2(MAX_LAT + 1);

    localparam logic [CTR_W-1:0] MULT_LOAD = CTR_W'(MULT_LAT - 1);
    localparam logic [CTR_W-1:0] DIV_LOAD  = CTR_W'(DIV_LAT - 1);
    localparam logic [CTR_W-1:0] CNT_ONE   = CTR_W'(1);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } mdu_state_t;

    mdu_state_t       state;
    logic [CTR_W-1:0] count;
    logic             done_q;

    // A start seen while BUSY is ignored: the running count is kept, since
    // the hazard logic should never let a second MDU op reach EX early.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            count  <= '0;
            done_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state <= BUSY;
                        count <= is_div ? DIV_LOAD : MULT_LOAD;
                    end
                end
                BUSY: begin
                    if (count == CNT_ONE) begin
                        state  <= IDLE;
                        count  <= '0;
                        done_q <= 1'b1;
                    end else begin
                        count  <= count - CNT_ONE;
                        done_q <= 1'b0;
                    end
                end
                default: begin
                    state  <= IDLE;
                    count  <= '0;
                    done_q <= 1'b0;
                end
            endcase
        end
    end

    assign busy      = (state == BUSY);
    assign done      = done_q;
    assign done_next = (state == BUSY) && (count == CNT_ONE);

endmodule

// File: rtl/hazard_stall_unit.sv
// Stall/bubble generator between ID and ID_EX: catches load-use, load-into-branch
// and MDU-result hazards that forwarding cannot resolve, and counts stall cycles.
module hazard_stall_unit
    import my_lib::*;
#(
    parameter int MULT_LAT = MULT_LAT_DEF,
    parameter int DIV_LAT  = DIV_LAT_DEF,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             id_valid,
    input  logic [4:0]       id_rs,
    input  logic [4:0]       id_rt,
    input  logic             id_use_rs,
    input  logic             id_use_rt,
    input  logic             id_is_branch,
    input  logic             id_is_hilo,
    input  logic             id_is_mdu,
    input  logic             ex_mem_read,
    input  logic             ex_reg_write,
    input  logic [4:0]       ex_rd,
    input  logic             ex_mdu_start,
    input  logic             ex_mdu_is_div,
    input  logic             mem_mem_read,
    input  logic [4:0]       mem_rd,
    output logic             stall,
    output logic             bubble,
    output logic [1:0]       stall_cause,
    output logic             mdu_busy,
    output logic             mdu_done,
    output logic [CNT_W-1:0] stall_cycles
);

    logic         mdu_done_next;
    logic         hazard_en;
    logic         ex_hit;
    logic         mem_hit;
    logic         load_use;
    logic         branch_load;
    logic         mdu_wait;
    logic         any_stall;
    stall_cause_t cause;
    logic         unused_inputs;

    mdu_busy_timer #(
        .MULT_LAT (MULT_LAT),
        .DIV_LAT  (DIV_LAT)
    ) u_mdu_timer (
        .clk       (clk),
        .reset     (reset),
        .start     (ex_mdu_start),
        .is_div    (ex_mdu_is_div),
        .busy      (mdu_busy),
        .done      (mdu_done),
        .done_next (mdu_done_next)
    );

    // ALU results are forwarded into both EX and ID, so a plain register write
    // in ID_EX never needs a stall; only loads and the MDU do.
    assign unused_inputs = ex_reg_write;

    assign hazard_en = id_valid && !reset;
    assign ex_hit    = src_match(ex_rd, id_rs, id_rt, id_use_rs, id_use_rt);
    assign mem_hit   = mem_mem_read && src_match(mem_rd, id_rs, id_rt, id_use_rs, id_use_rt);

    assign load_use    = hazard_en && ex_mem_read && ex_hit;
    assign branch_load = hazard_en && id_is_branch && (mem_hit || load_use);
    assign mdu_wait    = hazard_en && mdu_busy && !mdu_done_next && (id_is_hilo || id_is_mdu);

    assign any_stall = load_use || branch_load || mdu_wait;
    assign stall     = any_stall;
    assign bubble    = any_stall;

    always_comb begin
        cause = NONE;
        if (branch_load) begin
            cause = BRANCH_LOAD;
        end else if (load_use) begin
            cause = LOAD_USE;
        end else if (mdu_wait) begin
            cause = MDU;
        end
    end

    assign stall_cause = cause;

    // Saturating performance counter: holds at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cycles <= '0;
        end else if (any_stall && (stall_cycles != {CNT_W{1'b1}})) begin
            stall_cycles <= stall_cycles + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_hazard_stall_unit.sv
// Scoreboard bench for hazard_stall_unit: directed pipeline scenarios followed by
// randomized traffic, all checked against a cycle-level behavioural model.
module tb_hazard_stall_unit;
    import my_lib::*;

    localparam int CNT_W  = 4;
    localparam int SAT    = 15;
    localparam int T_MULT = 5;
    localparam int T_DIV  = 32;

    logic             clk;
    logic             reset;
    logic             id_valid;
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_use_rs;
    logic             id_use_rt;
    logic             id_is_branch;
    logic             id_is_hilo;
    logic             id_is_mdu;
    logic             ex_mem_read;
    logic             ex_reg_write;
    logic [4:0]       ex_rd;
    logic             ex_mdu_start;
    logic             ex_mdu_is_div;
    logic             mem_mem_read;
    logic [4:0]       mem_rd;
    logic             stall;
    logic             bubble;
    logic [1:0]       stall_cause;
    logic             mdu_busy;
    logic             mdu_done;
    logic [CNT_W-1:0] stall_cycles;

    typedef struct {
        logic       id_valid;
        logic [4:0] id_rs;
        logic [4:0] id_rt;
        logic       id_use_rs;
        logic       id_use_rt;
        logic       id_is_branch;
        logic       id_is_hilo;
        logic       id_is_mdu;
        logic       ex_mem_read;
        logic       ex_reg_write;
        logic [4:0] ex_rd;
        logic       ex_mdu_start;
        logic       ex_mdu_is_div;
        logic       mem_mem_read;
        logic [4:0] mem_rd;
    } stim_t;

    typedef struct {
        int cyc;
        int stall;
        int bubble;
        int cause;
        int busy;
        int done;
        int sc;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Model state: remaining busy cycles of the MDU, pending done pulse, stall total.
    int busy_left = 0;
    int done_m    = 0;
    int sc_m      = 0;

    hazard_stall_unit #(
        .MULT_LAT (T_MULT),
        .DIV_LAT  (T_DIV),
        .CNT_W    (CNT_W)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .id_valid      (id_valid),
        .id_rs         (id_rs),
        .id_rt         (id_rt),
        .id_use_rs     (id_use_rs),
        .id_use_rt     (id_use_rt),
        .id_is_branch  (id_is_branch),
        .id_is_hilo    (id_is_hilo),
        .id_is_mdu     (id_is_mdu),
        .ex_mem_read   (ex_mem_read),
        .ex_reg_write  (ex_reg_write),
        .ex_rd         (ex_rd),
        .ex_mdu_start  (ex_mdu_start),
        .ex_mdu_is_div (ex_mdu_is_div),
        .mem_mem_read  (mem_mem_read),
        .mem_rd        (mem_rd),
        .stall         (stall),
        .bubble        (bubble),
        .stall_cause   (stall_cause),
        .mdu_busy      (mdu_busy),
        .mdu_done      (mdu_done),
        .stall_cycles  (stall_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic stim_t idle_stim();
        stim_t s;
        s.id_valid = 0; s.id_rs = 0; s.id_rt = 0; s.id_use_rs = 0; s.id_use_rt = 0;
        s.id_is_branch = 0; s.id_is_hilo = 0; s.id_is_mdu = 0;
        s.ex_mem_read = 0; s.ex_reg_write = 0; s.ex_rd = 0;
        s.ex_mdu_start = 0; s.ex_mdu_is_div = 0;
        s.mem_mem_read = 0; s.mem_rd = 0;
        return s;
    endfunction

    function automatic bit reads_reg(input stim_t s, input logic [4:0] r);
        return (r != 5'd0) && ((s.id_use_rs && s.id_rs == r) || (s.id_use_rt && s.id_rt == r));
    endfunction

    task automatic check_output(input string name, input int c, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("[TB] FAIL %s cycle=%0d got=%0d expected=%0d", name, c, got, want);
        end
    endtask

    // Drives one cycle of inputs, records what the DUT must show during it,
    // then advances the model to the state the next clock edge produces.
    task automatic apply_stimulus(input stim_t s, input bit rst_v);
        exp_t e;
        bit lu, bl, md;
        @(posedge clk);
        #1;
        cyc++;
        reset = rst_v;
        id_valid = s.id_valid; id_rs = s.id_rs; id_rt = s.id_rt;
        id_use_rs = s.id_use_rs; id_use_rt = s.id_use_rt;
        id_is_branch = s.id_is_branch; id_is_hilo = s.id_is_hilo; id_is_mdu = s.id_is_mdu;
        ex_mem_read = s.ex_mem_read; ex_reg_write = s.ex_reg_write; ex_rd = s.ex_rd;
        ex_mdu_start = s.ex_mdu_start; ex_mdu_is_div = s.ex_mdu_is_div;
        mem_mem_read = s.mem_mem_read; mem_rd = s.mem_rd;
        e.cyc = cyc;
        if (rst_v) begin
            busy_left = 0; done_m = 0; sc_m = 0;
            e.stall = 0; e.bubble = 0; e.cause = 0; e.busy = 0; e.done = 0; e.sc = 0;
        end else begin
            lu = s.id_valid && s.ex_mem_read && reads_reg(s, s.ex_rd);
            bl = s.id_valid && s.id_is_branch && ((s.mem_mem_read && reads_reg(s, s.mem_rd)) || lu);
            md = s.id_valid && (busy_left > 1) && (s.id_is_hilo || s.id_is_mdu);
            e.stall  = (lu || bl || md) ? 1 : 0;
            e.bubble = e.stall;
            e.cause  = bl ? 2 : (lu ? 1 : (md ? 3 : 0));
            e.busy   = (busy_left > 0) ? 1 : 0;
            e.done   = done_m;
            e.sc     = (sc_m > SAT) ? SAT : sc_m;
            if (e.stall != 0) sc_m++;
            done_m = (busy_left == 1) ? 1 : 0;
            if (busy_left > 0) busy_left--;
            else if (s.ex_mdu_start) busy_left = (s.ex_mdu_is_div ? T_DIV : T_MULT) - 1;
        end
        exp_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            check_output("stall",        e.cyc, int'(stall),        e.stall);
            check_output("bubble",       e.cyc, int'(bubble),       e.bubble);
            check_output("stall_cause",  e.cyc, int'(stall_cause),  e.cause);
            check_output("mdu_busy",     e.cyc, int'(mdu_busy),     e.busy);
            check_output("mdu_done",     e.cyc, int'(mdu_done),     e.done);
            check_output("stall_cycles", e.cyc, int'(stall_cycles), e.sc);
        end
    end

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog cycle=%0d got=timeout expected=finish", cyc);
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        stim_t s;
        stim_t lu_s;
        reset = 1'b1;
        s = idle_stim();
        apply_stimulus(s, 1);
        apply_stimulus(s, 1);
        apply_stimulus(s, 0);

        // Load-use: lw $8 in ID_EX, add reading $8 in ID; then the lw moves on.
        s = idle_stim();
        s.id_valid = 1; s.id_rs = 8; s.id_rt = 3; s.id_use_rs = 1; s.id_use_rt = 1;
        s.ex_mem_read = 1; s.ex_reg_write = 1; s.ex_rd = 8;
        lu_s = s;
        apply_stimulus(s, 0);
        s.ex_mem_read = 0; s.ex_reg_write = 0; s.ex_rd = 0;
        s.mem_mem_read = 1; s.mem_rd = 8;
        apply_stimulus(s, 0);
        s = lu_s; s.ex_rd = 0; s.id_rs = 0;
        apply_stimulus(s, 0);
        s = lu_s; s.id_valid = 0;
        apply_stimulus(s, 0);

        // Branch after load: lw $9 then beq $9,$0 stalls twice.
        s = idle_stim();
        s.id_valid = 1; s.id_is_branch = 1; s.id_rs = 9; s.id_rt = 0; s.id_use_rs = 1; s.id_use_rt = 1;
        s.ex_mem_read = 1; s.ex_reg_write = 1; s.ex_rd = 9;
        apply_stimulus(s, 0);
        s.ex_mem_read = 0; s.ex_reg_write = 0; s.ex_rd = 0;
        s.mem_mem_read = 1; s.mem_rd = 9;
        apply_stimulus(s, 0);
        s.mem_mem_read = 0; s.mem_rd = 0;
        apply_stimulus(s, 0);

        // Branch after ALU op: forwarded, no stall.
        s = idle_stim();
        s.id_valid = 1; s.id_is_branch = 1; s.id_rs = 10; s.id_use_rs = 1;
        s.ex_reg_write = 1; s.ex_rd = 10;
        apply_stimulus(s, 0);

        // Divide then mflo held in ID, then the same with mult.
        for (int k = 0; k < 2; k++) begin
            s = idle_stim();
            s.id_valid = 1; s.id_is_hilo = 1;
            s.ex_mdu_start = 1; s.ex_mdu_is_div = (k == 0);
            apply_stimulus(s, 0);
            s.ex_mdu_start = 0; s.ex_mdu_is_div = 0;
            for (int i = 0; i < ((k == 0) ? T_DIV + 2 : T_MULT + 2); i++) apply_stimulus(s, 0);
        end

        // Reset in the middle of a divide aborts it with no done pulse.
        s = idle_stim();
        s.id_valid = 1; s.id_is_mdu = 1;
        s.ex_mdu_start = 1; s.ex_mdu_is_div = 1;
        apply_stimulus(s, 0);
        s.ex_mdu_start = 0;
        for (int i = 0; i < 9; i++) apply_stimulus(s, 0);
        apply_stimulus(s, 1);
        s.id_valid = 0;
        for (int i = 0; i < 4; i++) apply_stimulus(s, 0);

        // Saturation: hold a load-use for 20 cycles.
        for (int i = 0; i < 20; i++) apply_stimulus(lu_s, 0);

        // Randomized traffic over a small register set so hits are frequent.
        apply_stimulus(idle_stim(), 1);
        for (int i = 0; i < 500; i++) begin
            s.id_valid      = ($urandom_range(0, 3) != 0);
            s.id_rs         = 5'($urandom_range(0, 3));
            s.id_rt         = 5'($urandom_range(0, 3));
            s.id_use_rs     = 1'($urandom_range(0, 1));
            s.id_use_rt     = 1'($urandom_range(0, 1));
            s.id_is_branch  = ($urandom_range(0, 3) == 0);
            s.id_is_hilo    = ($urandom_range(0, 3) == 0);
            s.id_is_mdu     = ($urandom_range(0, 7) == 0);
            s.ex_mem_read   = 1'($urandom_range(0, 1));
            s.ex_reg_write  = 1'($urandom_range(0, 1));
            s.ex_rd         = 5'($urandom_range(0, 3));
            s.ex_mdu_start  = ($urandom_range(0, 9) == 0);
            s.ex_mdu_is_div = ($urandom_range(0, 3) == 0);
            s.mem_mem_read  = 1'($urandom_range(0, 1));
            s.mem_rd        = 5'($urandom_range(0, 3));
            apply_stimulus(s, ($urandom_range(0, 149) == 0));
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        check_output("scoreboard_drained", cyc, exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
